// File: rtl/alsu_seg_display_ctrl.sv
// Purpose : ALSU display stage; latches a 16-bit result plus error flag and scans it onto a 4-digit common-anode 7-segment display.
// Latency : a value loaded mid-frame shows from digit0 of the next frame; a load on the frame-boundary cycle shows on that same edge.
// Backpressure: none; load is a fire-and-forget strobe, and a later load before the boundary overwrites the pending one.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous, active-low reset
//   load     in   1   1-cycle strobe: capture data_in/err_in
//   data_in  in   16  value to show; [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   err_in   in   1   1 = show "E404"
//   anode    out  4   digit enables, active-low; anode[i] drives digit i
//   cathode  out  7   segments {g,f,e,d,c,b,a}, active-low
module alsu_seg_display_ctrl #(
  parameter int    CLK_DIV       = 25000,
  parameter string BLANK_LEADING = "OFF"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        err_in,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam bit            BLANK     = (BLANK_LEADING == "ON");

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("alsu_seg_display_ctrl: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          run;       // low until the first tick, so that tick shows digit0
  logic [15:0]   pend, disp;
  logic          pend_err, disp_err, pend_v;

  logic          tick, boundary;
  logic [1:0]    idx_next;
  logic [15:0]   disp_nxt;
  logic          err_nxt;
  logic [3:0]    nib;
  logic [6:0]    cat_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign tick     = (presc == PRESC_MAX);
  assign idx_next = run ? idx + 2'd1 : 2'd0;
  // Every tick that lands on digit0 starts a frame (idx 3->0, or the first tick after reset).
  assign boundary = tick && (idx_next == 2'd0);

  // Value disp will hold after this edge; the digit driven on a boundary edge must already use it.
  always_comb begin
    disp_nxt = disp;
    err_nxt  = disp_err;
    if (boundary) begin
      if (load) begin
        disp_nxt = data_in;
        err_nxt  = err_in;
      end else if (pend_v) begin
        disp_nxt = pend;
        err_nxt  = pend_err;
      end
    end
  end

  always_comb begin
    nib     = disp_nxt[{idx_next, 2'b00} +: 4];
    cat_nxt = seg7(nib);
    if (err_nxt) begin
      case (idx_next)
        2'd0:    cat_nxt = 7'h19;  // '4'
        2'd1:    cat_nxt = 7'h40;  // '0'
        2'd2:    cat_nxt = 7'h19;  // '4'
        default: cat_nxt = 7'h06;  // 'E'
      endcase
    end else if (BLANK && (idx_next != 2'd0) &&
                 ((disp_nxt >> {idx_next, 2'b00}) == 16'd0)) begin
      // Digits idx_next..3 are all zero: leading zero, segments off, anode still driven.
      cat_nxt = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      idx      <= 2'd0;
      run      <= 1'b0;
      pend     <= 16'd0;
      pend_err <= 1'b0;
      pend_v   <= 1'b0;
      disp     <= 16'd0;
      disp_err <= 1'b0;
      anode    <= 4'b1111;
      cathode  <= 7'h7F;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      disp     <= disp_nxt;
      disp_err <= err_nxt;

      if (tick) begin
        idx     <= idx_next;
        run     <= 1'b1;
        anode   <= ~(4'b0001 << idx_next);
        cathode <= cat_nxt;
      end

      // A load on the boundary bypasses pend entirely (handled in disp_nxt).
      if (load && !boundary) begin
        pend     <= data_in;
        pend_err <= err_in;
        pend_v   <= 1'b1;
      end else if (boundary) begin
        pend_v   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alsu_seg_display_ctrl.sv
// Directed bench for alsu_seg_display_ctrl with CLK_DIV=4 (4ns clock).
// Two instances share stimulus: dut with leading-zero blanking off, dut_b with it on.
// Edge counter e restarts at 0 on each reset release; tick k lands on edge 4k and frame f on edges 16f+4..16f+19.
`timescale 1ns/1ps
module tb_alsu_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        err_in = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [3:0]  anode, anode_b;
  logic [6:0]  cathode, cathode_b;

  int checks = 0;
  int errors = 0;
  int e = 0;
  bit mon_en = 1'b0;

  always #2 clk = ~clk;

  alsu_seg_display_ctrl #(.CLK_DIV(4), .BLANK_LEADING("OFF")) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .err_in(err_in),
    .anode(anode), .cathode(cathode)
  );

  alsu_seg_display_ctrl #(.CLK_DIV(4), .BLANK_LEADING("ON")) dut_b (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .err_in(err_in),
    .anode(anode_b), .cathode(cathode_b)
  );

  // Never two digits enabled at once.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ((anode === 4'hF || $onehot(~anode)) && (anode_b === 4'hF || $onehot(~anode_b)))
        else begin
          errors++;
          $error("FAIL onehot: observed anode=%b anode_b=%b required one-hot-low or 1111", anode, anode_b);
        end
    end
  end

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed anode/cathode=%b/%h expected %b/%h", tag, obs[10:7], obs[6:0], exp[10:7], exp[6:0]);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto_edge(input int n);
    while (e < n) step();
  endtask

  task automatic check_slot(input string tag, input bit sel, input int f, input int d, input logic [6:0] cat);
    logic [3:0] an;
    an = 4'b1111 ^ (4'b0001 << d);
    goto_edge(16*f + 4*(d+1));
    chk($sformatf("%s_d%0d", tag, d), sel ? {anode_b, cathode_b} : {anode, cathode}, {an, cat});
    goto_edge(16*f + 4*(d+1) + 3);
    chk($sformatf("%s_d%0d_hold", tag, d), sel ? {anode_b, cathode_b} : {anode, cathode}, {an, cat});
  endtask

  task automatic check_frame(input string tag, input bit sel, input int f,
                             input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3);
    check_slot(tag, sel, f, 0, c0);
    check_slot(tag, sel, f, 1, c1);
    check_slot(tag, sel, f, 2, c2);
    check_slot(tag, sel, f, 3, c3);
  endtask

  // Strobe load for one cycle so it is captured on edge 'at'.
  task automatic do_load(input int at, input logic [15:0] v, input logic er);
    goto_edge(at - 1);
    load = 1'b1;
    data_in = v;
    err_in = er;
    step();
    load = 1'b0;
    data_in = 16'd0;
    err_in = 1'b0;
  endtask

  // Assert reset between edges, check outputs blank immediately, release between edges.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_now"}, {anode, cathode}, {4'b1111, 7'h7F});
    chk({tag, "_now_b"}, {anode_b, cathode_b}, {4'b1111, 7'h7F});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    e = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // 1: reset and first tick
    reset_pulse("t1_rst");
    mon_en = 1'b1;
    goto_edge(3);
    chk("t1_before_tick", {anode, cathode}, {4'b1111, 7'h7F});
    check_slot("t1", 1'b0, 0, 0, 7'h40);

    // 2: mid-frame load; rest of frame 0 unchanged, frame 1 shows 12AF
    do_load(10, 16'h12AF, 1'b0);
    check_slot("t2_old", 1'b0, 0, 2, 7'h40);
    check_slot("t2_old", 1'b0, 0, 3, 7'h40);
    check_frame("t2_12AF", 1'b0, 1, 7'h0E, 7'h08, 7'h24, 7'h79);

    // 3: error mode, then back to zero
    do_load(38, 16'hFFFF, 1'b1);
    check_slot("t3_prev", 1'b0, 2, 1, 7'h08);
    check_frame("t3_E404", 1'b0, 3, 7'h19, 7'h40, 7'h19, 7'h06);
    do_load(70, 16'h0000, 1'b0);
    check_frame("t3_zero", 1'b0, 5, 7'h40, 7'h40, 7'h40, 7'h40);

    // 4: load while idx=1, then a load on the boundary edge
    do_load(105, 16'h1234, 1'b0);
    check_slot("t4_old", 1'b0, 6, 2, 7'h40);
    check_slot("t4_old", 1'b0, 6, 3, 7'h40);
    check_frame("t4_1234", 1'b0, 7, 7'h19, 7'h30, 7'h24, 7'h79);
    do_load(132, 16'h5678, 1'b0);
    check_frame("t4_bnd_5678", 1'b0, 8, 7'h00, 7'h78, 7'h02, 7'h12);

    // 5: leading-zero blanking on dut_b
    do_load(150, 16'h0005, 1'b0);
    check_frame("t5_0005", 1'b1, 10, 7'h12, 7'h7F, 7'h7F, 7'h7F);
    do_load(182, 16'h0000, 1'b0);
    check_frame("t5_0000", 1'b1, 12, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    do_load(214, 16'h0105, 1'b0);
    check_frame("t5_0105", 1'b1, 14, 7'h12, 7'h40, 7'h79, 7'h7F);
    do_load(246, 16'h0000, 1'b1);
    check_frame("t5_err", 1'b1, 16, 7'h19, 7'h40, 7'h19, 7'h06);

    // 6: reset mid-frame drops the pending load
    do_load(278, 16'hABCD, 1'b0);
    goto_edge(285);
    reset_pulse("t6_rst");
    goto_edge(3);
    chk("t6_before_tick", {anode, cathode}, {4'b1111, 7'h7F});
    check_frame("t6_after", 1'b0, 0, 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("t6_after_b", 1'b1, 1, 7'h40, 7'h7F, 7'h7F, 7'h7F);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
